multicycle_control: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle control decoder. A Moore FSM sequences

---
 rtl/multicycle_control_pkg.sv | 14 +
 rtl/multicycle_control_if.sv | 23 ++
 rtl/multicycle_control_decode.sv | 22 ++
 rtl/multicycle_control.sv | 85 ++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state, instruction class, opcode and ALU op encodings
package multicycle_control_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_ERR
   } state_t;
   typedef enum logic [2:0] {CLS_ALU, CLS_LD, CLS_ST, CLS_BR, CLS_HALT} cls_t;
   localparam logic [2:0] OP_STORE = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_LOAD  = 3'b010;
   localparam logic [2:0] OP_HALT  = 3'b110;
   localparam logic [2:0] OP_BR    = 3'b111;
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_PASS = 3'b111;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller handshake and datapath control bundle
interface multicycle_control_if #(
   parameter int OPWIDTH   = 3,
   parameter int MCODEBITS = 3,
   parameter int CNTW      = 16
);
   logic                 Start, br_logic, mem_ready;
   logic [MCODEBITS-1:0] instr;
   logic                 ir_load, mem_req, RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite;
   logic [OPWIDTH-1:0]   ALUOp;
   logic                 Done, err;
   logic [CNTW-1:0]      retired;
   modport master (
      input  Start, instr, br_logic, mem_ready,
      output ir_load, mem_req, RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
             ALUOp, Done, err, retired
   );
   modport slave (
      output Start, instr, br_logic, mem_ready,
      input  ir_load, mem_req, RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
             ALUOp, Done, err, retired
   );
endinterface

// File: rtl/multicycle_control_decode.sv
// multicycle_control_decode: latched opcode to instruction class, ALU op and operand select
module multicycle_control_decode
   import multicycle_control_pkg::*;
#(
   parameter int OPWIDTH   = 3,
   parameter int MCODEBITS = 3
) (
   input  logic [MCODEBITS-1:0] op,
   output cls_t                 cls,
   output logic [OPWIDTH-1:0]   alu_op,
   output logic                 alu_src
);
   // opcodes are zero-extended so wider opcode fields decode identically
   always_comb begin
      cls = op == MCODEBITS'(OP_LOAD)  ? CLS_LD :
            op == MCODEBITS'(OP_STORE) ? CLS_ST :
            op == MCODEBITS'(OP_BR)    ? CLS_BR :
            op == MCODEBITS'(OP_HALT)  ? CLS_HALT : CLS_ALU;
      alu_op  = op == MCODEBITS'(OP_ADD) ? OPWIDTH'(ALU_ADD) : '1;
      alu_src = cls == CLS_LD || cls == CLS_ST;
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle Moore sequencer with memory stall timeout and retire counter
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int OPWIDTH   = 3,
   parameter int MCODEBITS = 3,
   parameter int MAX_STALL = 15,
   parameter int CNTW      = 16
) (
   input logic                 Clk,
   input logic                 Reset,
   multicycle_control_if.master bus
);
   localparam int SW = $clog2(MAX_STALL + 1);
   state_t               state_q, state_d;
   logic [MCODEBITS-1:0] op_q;
   logic [SW-1:0]        stall_cnt;
   logic [CNTW-1:0]      retired_q;
   cls_t                 cls;
   logic [OPWIDTH-1:0]   alu_op;
   logic                 alu_src, retire;

   multicycle_control_decode #(.OPWIDTH(OPWIDTH), .MCODEBITS(MCODEBITS)) u_decode (
      .op(op_q), .cls(cls), .alu_op(alu_op), .alu_src(alu_src)
   );

   // state, latched opcode, stall counter (cleared whenever MEM is left) and retire count
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         stall_cnt <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         if (state_q == S_DECODE) op_q <= bus.instr;
         stall_cnt <= (state_q == S_MEM && state_d == S_MEM) ? stall_cnt + 1'b1 : '0;
         if (retire) retired_q <= retired_q + 1'b1;
      end
   end

   // next state and retire event; a late mem_ready on the timeout cycle still completes
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: if (bus.Start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            retire  = cls == CLS_BR || cls == CLS_HALT;
            state_d = cls == CLS_BR ? S_FETCH :
                      cls == CLS_HALT ? S_DONE :
                      (cls == CLS_LD || cls == CLS_ST) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               retire  = cls == CLS_ST;
               state_d = cls == CLS_ST ? S_FETCH : S_WB;
            end else if (stall_cnt == SW'(MAX_STALL)) state_d = S_ERR;
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = state_q;
      endcase
   end

   // datapath controls decoded from state and latched opcode; ALU controls held EXEC..WB
   always_comb begin
      bus.ir_load  = state_q == S_FETCH;
      bus.mem_req  = state_q == S_MEM;
      bus.RegDst   = 1'b0;
      bus.Branch   = state_q == S_EXEC && cls == CLS_BR && bus.br_logic;
      bus.MemtoReg = state_q == S_WB && cls == CLS_LD;
      bus.MemWrite = state_q == S_MEM && cls == CLS_ST;
      bus.ALUSrc   = (state_q == S_EXEC || state_q == S_MEM) && alu_src;
      bus.RegWrite = state_q == S_WB;
      bus.ALUOp    = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) ? alu_op : '1;
      bus.Done     = state_q == S_DONE;
      bus.err      = state_q == S_ERR;
      bus.retired  = retired_q;
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenario checks of the multi-cycle controller
module tb_multicycle_control;
   import multicycle_control_pkg::*;
   logic clk = 1'b0;
   logic Reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   localparam logic [9:0] F      = 10'b1000000000;
   localparam logic [9:0] Z      = 10'b0000000000;
   localparam logic [9:0] EX_LS  = 10'b0000001000;
   localparam logic [9:0] MEM_LD = 10'b0100001000;
   localparam logic [9:0] MEM_ST = 10'b0100011000;
   localparam logic [9:0] WB_ALU = 10'b0000000100;
   localparam logic [9:0] WB_LD  = 10'b0000100100;
   localparam logic [9:0] EX_BR  = 10'b0001000000;
   localparam logic [9:0] DN     = 10'b0000000010;
   localparam logic [9:0] ER     = 10'b0000000001;

   multicycle_control_if bus ();
   multicycle_control dut (.Clk(clk), .Reset(Reset), .bus(bus.master));
   multicycle_control_if #(.OPWIDTH(4), .MCODEBITS(4), .CNTW(4)) bus4 ();
   multicycle_control #(.OPWIDTH(4), .MCODEBITS(4), .CNTW(4)) dut4 (.Clk(clk), .Reset(Reset), .bus(bus4.master));

   always #5 clk = ~clk;

   function automatic logic [9:0] flags();
      return {bus.ir_load, bus.mem_req, bus.RegDst, bus.Branch, bus.MemtoReg,
              bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.Done, bus.err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      bus.Start = 1'b0; bus.mem_ready = 1'b0; bus.br_logic = 1'b0; bus.instr = '0;
      bus4.Start = 1'b0; bus4.mem_ready = 1'b0; bus4.br_logic = 1'b0; bus4.instr = '0;
      tick();
      Reset = 1'b0;
   endtask

   task automatic launch(input logic [2:0] op);
      bus.instr = op;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (flags() !== Z) begin fails++; $display("FAIL reset_flags got=%b exp=%b", flags(), Z); end
      tests++; if (bus.ALUOp !== 3'b111) begin fails++; $display("FAIL reset_aluop got=%b exp=111", bus.ALUOp); end
      tests++; if (bus.retired !== 16'd0) begin fails++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
      tick();
      tests++; if (flags() !== Z) begin fails++; $display("FAIL idle_hold got=%b exp=%b", flags(), Z); end
   endtask

   task automatic test_alu();
      logic [9:0] ef [4] = '{F, Z, Z, WB_ALU};
      do_reset();
      launch(OP_ADD);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         tests++; if (flags() !== ef[i]) begin fails++; $display("FAIL alu_cycle%0d got=%b exp=%b", i + 1, flags(), ef[i]); end
         if (i == 2) begin
            tests++; if (bus.ALUOp !== 3'b000) begin fails++; $display("FAIL alu_aluop got=%b exp=000", bus.ALUOp); end
         end
      end
      tick();
      tests++; if (flags() !== F) begin fails++; $display("FAIL alu_refetch got=%b exp=%b", flags(), F); end
      tests++; if (bus.retired !== 16'd1) begin fails++; $display("FAIL alu_retired got=%0d exp=1", bus.retired); end
   endtask

   task automatic test_memory();
      do_reset();
      launch(OP_LOAD);
      tick(); tick();
      tests++; if (flags() !== EX_LS) begin fails++; $display("FAIL ld_exec got=%b exp=%b", flags(), EX_LS); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) bus.mem_ready = 1'b1;
         tests++; if (flags() !== MEM_LD) begin fails++; $display("FAIL ld_mem%0d got=%b exp=%b", i, flags(), MEM_LD); end
      end
      tick();
      bus.mem_ready = 1'b0;
      tests++; if (flags() !== WB_LD) begin fails++; $display("FAIL ld_wb got=%b exp=%b", flags(), WB_LD); end
      bus.instr = OP_STORE;
      tick();
      tests++; if (flags() !== F || bus.retired !== 16'd1) begin fails++; $display("FAIL ld_done flags=%b retired=%0d exp=%b 1", flags(), bus.retired, F); end
      tick(); tick();
      tests++; if (flags() !== EX_LS || bus.ALUOp !== 3'b111) begin fails++; $display("FAIL st_exec got=%b/%b exp=%b/111", flags(), bus.ALUOp, EX_LS); end
      for (int i = 0; i < 2; i++) begin
         tick();
         if (i == 1) bus.mem_ready = 1'b1;
         tests++; if (flags() !== MEM_ST) begin fails++; $display("FAIL st_mem%0d got=%b exp=%b", i, flags(), MEM_ST); end
      end
      tick();
      bus.mem_ready = 1'b0;
      tests++; if (flags() !== F || bus.retired !== 16'd2) begin fails++; $display("FAIL st_done flags=%b retired=%0d exp=%b 2", flags(), bus.retired, F); end
   endtask

   task automatic test_branch();
      do_reset();
      bus.br_logic = 1'b1;
      launch(OP_BR);
      tick(); tick();
      tests++; if (flags() !== EX_BR) begin fails++; $display("FAIL br_taken got=%b exp=%b", flags(), EX_BR); end
      tick();
      tests++; if (flags() !== F || bus.retired !== 16'd1) begin fails++; $display("FAIL br_taken_ret flags=%b retired=%0d exp=%b 1", flags(), bus.retired, F); end
      bus.br_logic = 1'b0;
      tick(); tick();
      tests++; if (flags() !== Z) begin fails++; $display("FAIL br_not_taken got=%b exp=%b", flags(), Z); end
      bus.instr = 3'b011;
      tick();
      tests++; if (flags() !== F || bus.retired !== 16'd2) begin fails++; $display("FAIL br_nt_ret flags=%b retired=%0d exp=%b 2", flags(), bus.retired, F); end
      tick(); tick();
      tests++; if (flags() !== Z || bus.ALUOp !== 3'b111) begin fails++; $display("FAIL other_exec got=%b/%b exp=%b/111", flags(), bus.ALUOp, Z); end
      tick();
      tests++; if (flags() !== WB_ALU) begin fails++; $display("FAIL other_wb got=%b exp=%b", flags(), WB_ALU); end
   endtask

   task automatic test_stall();
      do_reset();
      launch(OP_STORE);
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         tests++; if (flags() !== MEM_ST) begin fails++; $display("FAIL stall_mem%0d got=%b exp=%b", i, flags(), MEM_ST); end
      end
      tick();
      tests++; if (flags() !== ER) begin fails++; $display("FAIL stall_err got=%b exp=%b", flags(), ER); end
      bus.Start = 1'b1;
      tick(); tick();
      bus.Start = 1'b0;
      tests++; if (flags() !== ER || bus.retired !== 16'd0) begin fails++; $display("FAIL err_sticky flags=%b retired=%0d exp=%b 0", flags(), bus.retired, ER); end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tests++; if (flags() !== Z) begin fails++; $display("FAIL err_reset got=%b exp=%b", flags(), Z); end
      launch(OP_STORE);
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 15) bus.mem_ready = 1'b1;
      end
      tick();
      bus.mem_ready = 1'b0;
      tests++; if (flags() !== F || bus.retired !== 16'd1) begin fails++; $display("FAIL stall_late_ready flags=%b retired=%0d exp=%b 1", flags(), bus.retired, F); end
   endtask

   task automatic test_halt();
      do_reset();
      launch(OP_HALT);
      tick(); tick(); tick();
      tests++; if (flags() !== DN || bus.retired !== 16'd1) begin fails++; $display("FAIL halt_done flags=%b retired=%0d exp=%b 1", flags(), bus.retired, DN); end
      tick();
      tests++; if (flags() !== DN) begin fails++; $display("FAIL halt_hold got=%b exp=%b", flags(), DN); end
      launch(OP_LOAD);
      tests++; if (flags() !== F) begin fails++; $display("FAIL halt_restart got=%b exp=%b", flags(), F); end
      tick(); tick(); tick();
      tests++; if (flags() !== MEM_LD) begin fails++; $display("FAIL halt_ld_mem got=%b exp=%b", flags(), MEM_LD); end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tests++; if (flags() !== Z || bus.ALUOp !== 3'b111 || bus.retired !== 16'd0) begin fails++; $display("FAIL mem_reset flags=%b aluop=%b retired=%0d exp=%b 111 0", flags(), bus.ALUOp, bus.retired, Z); end
   endtask

   task automatic test_wrap();
      do_reset();
      bus4.instr = 4'b0001;
      bus4.Start = 1'b1;
      tick();
      bus4.Start = 1'b0;
      for (int n = 0; n < 16; n++) begin
         tick(); tick();
         if (n == 0) begin
            tests++; if (bus4.ALUOp !== 4'b0000) begin fails++; $display("FAIL w4_aluop got=%b exp=0000", bus4.ALUOp); end
         end
         tick(); tick();
         if (n == 14) begin
            tests++; if (bus4.retired !== 4'd15) begin fails++; $display("FAIL w4_ret15 got=%0d exp=15", bus4.retired); end
         end
      end
      tests++; if (bus4.retired !== 4'd0 || bus4.ir_load !== 1'b1) begin fails++; $display("FAIL w4_wrap retired=%0d ir_load=%b exp=0 1", bus4.retired, bus4.ir_load); end
      bus4.instr = 4'b0010;
      tick(); tick();
      tests++; if (bus4.ALUSrc !== 1'b1 || bus4.ALUOp !== 4'b1111) begin fails++; $display("FAIL w4_load alusrc=%b aluop=%b exp=1 1111", bus4.ALUSrc, bus4.ALUOp); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_memory();
      test_branch();
      test_stall();
      test_halt();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
